// File: rtl/audio_spectrum_display_buffer_pkg.sv
// Shared definitions for the spectrum display frame buffer.
// Holds the one-hot write-state encoding, default geometry of a display
// frame, the width of the dropped-frame counter and its saturating
// increment helper.
package audio_display_pkg;

  localparam int DATA_WIDTH_DEF = 10;
  localparam int FRAME_LEN_DEF  = 256;
  localparam int ADDR_WIDTH_DEF = 8;
  localparam int DROP_W         = 8;

  // Write-side states, one-hot.
  typedef enum logic [2:0] {
    W_IDLE = 3'b001,
    W_FILL = 3'b010,
    W_PEND = 3'b100
  } w_state_t;

  // Dropped-frame counter sticks at all-ones instead of wrapping.
  function automatic logic [DROP_W-1:0] drop_inc(input logic [DROP_W-1:0] cnt);
    return (&cnt) ? cnt : cnt + DROP_W'(1);
  endfunction

endpackage

// File: rtl/audio_spectrum_display_buffer_frame_ram.sv
// Ping-pong frame storage: simple dual-port RAM, two banks of 2**ADDR_WIDTH
// words. The bank bit is the MSB of each address. Synchronous write and
// synchronous registered read; no reset so it maps onto block RAM.
// Ports:
//   clk_i    clock
//   we_i     write enable, waddr_i / wdata_i write address and data
//   re_i     read enable, raddr_i read address
//   rdata_o  registered read data, updated on the edge after re_i
module display_frame_ram #(
  parameter int DATA_WIDTH = 10,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH:0]   waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic                  re_i,
  input  logic [ADDR_WIDTH:0]   raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [2**(ADDR_WIDTH+1)];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_o <= mem_q[raddr_i];
  end

endmodule

// File: rtl/audio_spectrum_display_buffer.sv
// Receive side of the scaler-to-LCD display stream. Captures each magnitude
// frame into the back bank of a ping-pong RAM, swaps banks once the frame is
// complete and the renderer is not scanning, and serves the front bank
// through a one-cycle registered read port.
// Ports:
//   CLK, RESET_N             clock, asynchronous active-low reset
//   FRAME_VALID/START/END    incoming stream qualifiers, FRAME_DATA sample
//   RD_BUSY                  renderer mid-scan; holds off a bank swap
//   RD_EN, RD_ADDR           read request into the front bank
//   RD_DATA, RD_DATA_VALID   read result, one cycle after RD_EN
//   FRAME_AVAIL              a frame has been committed since reset
//   FRAME_SWAP               one-cycle pulse per bank swap
//   DROP_COUNT               saturating count of discarded frames
module audio_spectrum_display_buffer
  import audio_display_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int FRAME_LEN  = FRAME_LEN_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                  CLK,
  input  logic                  RESET_N,
  input  logic                  FRAME_VALID,
  input  logic                  FRAME_START,
  input  logic                  FRAME_END,
  input  logic [DATA_WIDTH-1:0] FRAME_DATA,
  input  logic                  RD_BUSY,
  input  logic                  RD_EN,
  input  logic [ADDR_WIDTH-1:0] RD_ADDR,
  output logic [DATA_WIDTH-1:0] RD_DATA,
  output logic                  RD_DATA_VALID,
  output logic                  FRAME_AVAIL,
  output logic                  FRAME_SWAP,
  output logic [DROP_W-1:0]     DROP_COUNT
);

  w_state_t              state_q;
  logic                  bank_q;      // front bank index; back is ~bank_q
  logic [ADDR_WIDTH:0]   addr_q;      // one extra bit so it can saturate at FRAME_LEN
  logic                  avail_q;
  logic                  swap_q;
  logic [DROP_W-1:0]     drop_q;
  logic                  rd_vld_q;
  logic                  rd_gate_q;   // read was issued with a committed frame present

  logic                  start_v;
  logic                  ram_we;
  logic [ADDR_WIDTH-1:0] ram_wbin;
  logic [DATA_WIDTH-1:0] ram_rdata;

  assign start_v = FRAME_VALID & FRAME_START;

  // Write port: a start always lands in bin 0; later samples land at the
  // running address until it reaches FRAME_LEN (top bit set).
  always_comb begin
    ram_we   = 1'b0;
    ram_wbin = addr_q[ADDR_WIDTH-1:0];
    unique case (state_q)
      W_IDLE: begin
        if (start_v) begin
          ram_we   = 1'b1;
          ram_wbin = '0;
        end
      end
      W_FILL: begin
        if (start_v) begin
          ram_we   = 1'b1;
          ram_wbin = '0;
        end else if (FRAME_VALID && !addr_q[ADDR_WIDTH]) begin
          ram_we = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= W_IDLE;
      bank_q  <= 1'b0;
      addr_q  <= '0;
      avail_q <= 1'b0;
      swap_q  <= 1'b0;
      drop_q  <= '0;
    end else begin
      swap_q <= 1'b0;
      unique case (state_q)
        W_IDLE: begin
          if (start_v) begin
            addr_q  <= (ADDR_WIDTH+1)'(1);
            state_q <= FRAME_END ? W_PEND : W_FILL;
          end
        end
        W_FILL: begin
          if (start_v) begin
            // Restart mid-frame: the partial frame is abandoned.
            addr_q <= (ADDR_WIDTH+1)'(1);
            drop_q <= drop_inc(drop_q);
            if (FRAME_END) state_q <= W_PEND;
          end else if (FRAME_VALID) begin
            if (!addr_q[ADDR_WIDTH]) addr_q <= addr_q + (ADDR_WIDTH+1)'(1);
            if (FRAME_END) state_q <= W_PEND;
          end
        end
        W_PEND: begin
          // Back bank is full and waiting; any new frame now is lost,
          // including one arriving on the swap edge itself.
          if (start_v) drop_q <= drop_inc(drop_q);
          if (!RD_BUSY) begin
            bank_q  <= ~bank_q;
            swap_q  <= 1'b1;
            avail_q <= 1'b1;
            state_q <= W_IDLE;
          end
        end
        default: state_q <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      rd_vld_q  <= 1'b0;
      rd_gate_q <= 1'b0;
    end else begin
      rd_vld_q  <= RD_EN;
      rd_gate_q <= RD_EN & avail_q;
    end
  end

  // Read uses the pre-edge bank select, so a read issued in the swap
  // cycle still sees the old front bank.
  display_frame_ram #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_ram (
    .clk_i  (CLK),
    .we_i   (ram_we),
    .waddr_i({~bank_q, ram_wbin}),
    .wdata_i(FRAME_DATA),
    .re_i   (RD_EN),
    .raddr_i({bank_q, RD_ADDR}),
    .rdata_o(ram_rdata)
  );

  assign RD_DATA       = rd_gate_q ? ram_rdata : '0;
  assign RD_DATA_VALID = rd_vld_q;
  assign FRAME_AVAIL   = avail_q;
  assign FRAME_SWAP    = swap_q;
  assign DROP_COUNT    = drop_q;

endmodule
